// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the five-stage pipeline.
// Drives hold/bubble controls of IF/ID, ID/EX, EX/MEM and MEM/WB from
// bus waits, load-use hazards, EX redirects and an optional multi-cycle EX unit.
// Optional feature macro: PIPE_MULTICYCLE_EX_EN (multi-cycle EX sequencing).
module pipe_hazard_ctrl #(
  parameter int unsigned MULTI_LAT = 16,
  parameter logic [63:0] RESET_PC  = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iwait,
  input  logic        dwait,
  input  logic        ex_redirect,
  input  logic [63:0] ex_redirect_pc,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_dst,
  input  logic        ex_multi_req,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        flush_if_id,
  output logic        bubble_ex,
  output logic        bubble_mem,
  output logic        ex_multi_done,
  output logic        pc_redirect,
  output logic [63:0] pc_redirect_pc,
  output logic [1:0]  ctrl_state
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MULTI      = 2'd1,
    REDIR_PEND = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        load_use;
  logic        multi_go;
  logic        s_if, s_id, s_ex, s_mem, fl_ifid, b_ex, b_mem, m_done, redir;

`ifdef PIPE_MULTICYCLE_EX_EN
  logic [5:0]  cnt_q, cnt_d;
  assign multi_go = ex_multi_req;
`else
  logic        unused_cfg;
  assign multi_go   = 1'b0;
  assign unused_cfg = ^{ex_multi_req, 6'(MULTI_LAT)};
`endif

  // Load-use hazard between the load in EX and the sources read in ID
  always_comb begin
    load_use = ex_valid && ex_is_load && (ex_dst != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_dst)) ||
                (id_uses_rs2 && (id_rs2 == ex_dst)));
  end

  // Prioritised control decode and next-state computation
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    s_if    = 1'b0;
    s_id    = 1'b0;
    s_ex    = 1'b0;
    s_mem   = 1'b0;
    fl_ifid = 1'b0;
    b_ex    = 1'b0;
    b_mem   = 1'b0;
    m_done  = 1'b0;
    redir   = 1'b0;
`ifdef PIPE_MULTICYCLE_EX_EN
    cnt_d   = cnt_q;
`endif
    if (dwait) begin
      s_if  = 1'b1;
      s_id  = 1'b1;
      s_ex  = 1'b1;
      s_mem = 1'b1;
    end else begin
      case (state_q)
        MULTI: begin
`ifdef PIPE_MULTICYCLE_EX_EN
          s_if = 1'b1;
          s_id = 1'b1;
          if (cnt_q != 6'd0) cnt_d = cnt_q - 6'd1;
          // The request cycle already counts as one, so the final
          // cycle is the one that takes the counter from 1 to 0.
          if (cnt_q <= 6'd1) begin
            m_done  = 1'b1;
            state_d = RUN;
          end else begin
            s_ex  = 1'b1;
            b_mem = 1'b1;
          end
`else
          state_d = RUN;
`endif
        end
        REDIR_PEND: begin
          s_if    = 1'b1;
          fl_ifid = 1'b1;
          if (ex_redirect) pc_d = ex_redirect_pc;
          if (!iwait) begin
            redir   = 1'b1;
            state_d = RUN;
          end
        end
        default: begin
          if (multi_go) begin
            s_if    = 1'b1;
            s_id    = 1'b1;
            s_ex    = 1'b1;
            b_mem   = 1'b1;
            state_d = MULTI;
`ifdef PIPE_MULTICYCLE_EX_EN
            cnt_d   = 6'(MULTI_LAT - 1);
`endif
          end else if (ex_redirect) begin
            fl_ifid = 1'b1;
            b_ex    = 1'b1;
            pc_d    = ex_redirect_pc;
            if (!iwait) redir   = 1'b1;
            else        state_d = REDIR_PEND;
          end else if (load_use) begin
            s_if = 1'b1;
            s_id = 1'b1;
            b_ex = 1'b1;
          end else if (iwait) begin
            s_if    = 1'b1;
            fl_ifid = 1'b1;
          end
        end
      endcase
    end
  end

  // State, counter and latched redirect target
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
`ifdef PIPE_MULTICYCLE_EX_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef PIPE_MULTICYCLE_EX_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Outputs are forced quiet while reset is held so an abort takes effect at once
  assign stall_if       = s_if    & ~reset;
  assign stall_id       = s_id    & ~reset;
  assign stall_ex       = s_ex    & ~reset;
  assign stall_mem      = s_mem   & ~reset;
  assign flush_if_id    = fl_ifid & ~reset;
  assign bubble_ex      = b_ex    & ~reset;
`ifdef PIPE_MULTICYCLE_EX_EN
  assign bubble_mem     = b_mem   & ~reset;
  assign ex_multi_done  = m_done  & ~reset;
`else
  assign bubble_mem     = 1'b0;
  assign ex_multi_done  = 1'b0;
`endif
  assign pc_redirect    = redir   & ~reset;
  assign pc_redirect_pc = reset ? RESET_PC : pc_d;
  assign ctrl_state     = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned LAT = 4;
  localparam logic [63:0] RPC = 64'h8000_0000;
`ifdef PIPE_MULTICYCLE_EX_EN
  localparam bit MC = 1'b1;
`else
  localparam bit MC = 1'b0;
`endif

  typedef struct packed {
    logic        iw, dw, rd;
    logic [63:0] rpc;
    logic [4:0]  rs1, rs2;
    logic        u1, u2, ev, ld;
    logic [4:0]  dst;
    logic        mreq;
  } stim_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        iwait, dwait, ex_redirect, id_uses_rs1, id_uses_rs2;
  logic        ex_valid, ex_is_load, ex_multi_req;
  logic [63:0] ex_redirect_pc;
  logic [4:0]  id_rs1, id_rs2, ex_dst;
  logic        stall_if, stall_id, stall_ex, stall_mem;
  logic        flush_if_id, bubble_ex, bubble_mem, ex_multi_done, pc_redirect;
  logic [63:0] pc_redirect_pc;
  logic [1:0]  ctrl_state;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: multi op tracked by elapsed effective cycles
  bit          m_multi, m_pend;
  int unsigned m_elapsed;
  logic [63:0] m_tgt;

  pipe_hazard_ctrl #(.MULTI_LAT(LAT), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .iwait(iwait), .dwait(dwait),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_dst(ex_dst),
    .ex_multi_req(ex_multi_req),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .stall_mem(stall_mem), .flush_if_id(flush_if_id), .bubble_ex(bubble_ex),
    .bubble_mem(bubble_mem), .ex_multi_done(ex_multi_done),
    .pc_redirect(pc_redirect), .pc_redirect_pc(pc_redirect_pc),
    .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t lu_stim();
    stim_t s;
    s = '0;
    s.ev = 1'b1; s.ld = 1'b1; s.dst = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
    return s;
  endfunction

  task automatic model_reset();
    m_multi = 1'b0; m_pend = 1'b0; m_elapsed = 0; m_tgt = RPC;
  endtask

  task automatic drive(input stim_t s);
    iwait = s.iw; dwait = s.dw; ex_redirect = s.rd; ex_redirect_pc = s.rpc;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
    ex_valid = s.ev; ex_is_load = s.ld; ex_dst = s.dst; ex_multi_req = s.mreq;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_stalls"}, 64'({stall_if, stall_id, stall_ex, stall_mem}), 64'd0);
    chk({tag, "_bubbles"}, 64'({flush_if_id, bubble_ex, bubble_mem}), 64'd0);
    chk({tag, "_done_redir"}, 64'({ex_multi_done, pc_redirect}), 64'd0);
    chk({tag, "_state"}, 64'(ctrl_state), 64'd0);
  endtask

  // One clock cycle: apply inputs at posedge+1, compare mid-cycle, advance model
  task automatic step(input stim_t s);
    logic        lu;
    logic        e_if, e_id, e_ex, e_mem, e_fl, e_bex, e_bmem, e_done, e_pcr;
    logic [1:0]  e_st;
    logic [63:0] e_pc;
    bit          n_multi, n_pend;
    int unsigned n_el;
    logic [63:0] n_tgt;
    drive(s);
    #2;
    lu = s.ev && s.ld && (s.dst != 0) &&
         ((s.u1 && s.rs1 == s.dst) || (s.u2 && s.rs2 == s.dst));
    {e_if, e_id, e_ex, e_mem, e_fl, e_bex, e_bmem, e_done, e_pcr} = '0;
    e_st = m_multi ? 2'd1 : (m_pend ? 2'd2 : 2'd0);
    n_multi = m_multi; n_pend = m_pend; n_el = m_elapsed; n_tgt = m_tgt;
    if (s.dw) begin
      {e_if, e_id, e_ex, e_mem} = '1;
    end else if (m_multi) begin
      e_if = 1'b1; e_id = 1'b1;
      if (m_elapsed + 1 == LAT) begin
        e_done = 1'b1; n_multi = 1'b0;
      end else begin
        e_ex = 1'b1; e_bmem = 1'b1; n_el = m_elapsed + 1;
      end
    end else if (!m_pend && MC && s.mreq) begin
      e_if = 1'b1; e_id = 1'b1; e_ex = 1'b1; e_bmem = 1'b1;
      n_multi = 1'b1; n_el = 1;
    end else if (!m_pend && s.rd) begin
      e_fl = 1'b1; e_bex = 1'b1; n_tgt = s.rpc;
      if (s.iw) n_pend = 1'b1;
      else      e_pcr = 1'b1;
    end else if (m_pend) begin
      e_if = 1'b1; e_fl = 1'b1;
      if (s.rd) n_tgt = s.rpc;
      if (!s.iw) begin e_pcr = 1'b1; n_pend = 1'b0; end
    end else if (lu) begin
      e_if = 1'b1; e_id = 1'b1; e_bex = 1'b1;
    end else if (s.iw) begin
      e_if = 1'b1; e_fl = 1'b1;
    end
    e_pc = n_tgt;
    chk("stall_if", 64'(stall_if), 64'(e_if));
    chk("stall_id", 64'(stall_id), 64'(e_id));
    chk("stall_ex", 64'(stall_ex), 64'(e_ex));
    chk("stall_mem", 64'(stall_mem), 64'(e_mem));
    chk("flush_if_id", 64'(flush_if_id), 64'(e_fl));
    chk("bubble_ex", 64'(bubble_ex), 64'(e_bex));
    chk("bubble_mem", 64'(bubble_mem), 64'(e_bmem));
    chk("multi_done", 64'(ex_multi_done), 64'(e_done));
    chk("pc_redirect", 64'(pc_redirect), 64'(e_pcr));
    chk("ctrl_state", 64'(ctrl_state), 64'(e_st));
    if (e_pcr) chk("redirect_pc", pc_redirect_pc, e_pc);
    @(posedge clk);
    #1;
    m_multi = n_multi; m_pend = n_pend; m_elapsed = n_el; m_tgt = n_tgt;
  endtask

  initial begin
    stim_t s;
    reset = 1'b1;
    drive(idle());
    model_reset();
    #1;
    check_quiet("in_reset");
    chk("reset_pc", pc_redirect_pc, RPC);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle after reset
    step(idle());
    chk("idle_pc", pc_redirect_pc, RPC);

    // Data wait dominates a load-use hazard, which is then served
    repeat (3) begin
      s = lu_stim(); s.dw = 1'b1;
      step(s);
    end
    step(lu_stim());

`ifdef PIPE_MULTICYCLE_EX_EN
    // Multi-cycle op with one overlapping data-wait cycle
    s = idle(); s.mreq = 1'b1;
    step(s);
    s = idle(); s.dw = 1'b1;
    step(s);
    repeat (4) step(idle());
`endif

    // Redirect while fetch is still outstanding
    s = idle(); s.rd = 1'b1; s.iw = 1'b1; s.rpc = 64'h8000_0100;
    step(s);
    s = idle(); s.iw = 1'b1;
    step(s);
    step(s);
    step(idle());

    // Redirect and load-use together with fetch idle
    s = lu_stim(); s.rd = 1'b1; s.rpc = 64'h8000_0240;
    step(s);

    // Asynchronous reset in the middle of a busy state
    s = idle();
`ifdef PIPE_MULTICYCLE_EX_EN
    s.mreq = 1'b1;
`else
    s.rd = 1'b1; s.iw = 1'b1; s.rpc = 64'h8000_0300;
`endif
    step(s);
    s = idle(); s.iw = 1'b1;
    drive(s);
    #2;
    chk("pre_abort_stall_if", 64'(stall_if), 64'd1);
    chk("pre_abort_busy", 64'(ctrl_state != 2'd0), 64'd1);
    reset = 1'b1;
    #1;
    check_quiet("abort");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (6) step(idle());

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      s.dw   = ($urandom_range(0, 4) == 0);
      s.iw   = ($urandom_range(0, 2) == 0);
      s.rd   = ($urandom_range(0, 7) == 0);
      s.rpc  = {$urandom, $urandom};
      s.rs1  = 5'($urandom_range(0, 3));
      s.rs2  = 5'($urandom_range(0, 3));
      s.dst  = 5'($urandom_range(0, 3));
      s.u1   = 1'($urandom_range(0, 1));
      s.u2   = 1'($urandom_range(0, 1));
      s.ev   = ($urandom_range(0, 3) != 0);
      s.ld   = 1'($urandom_range(0, 1));
      s.mreq = ($urandom_range(0, 9) == 0);
      step(s);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
